serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Multi-cycle sequencer that adds two W-bit operands by reusing one 2-bit ripple full-adder slice (add2b: x[1:0], y[1:0], ci -> o[1:0], co), LSB pair first.
- Processes one bit pair per clock and holds the running carry in a register between pairs.
- Sits between a requester (start/done handshake) and the shared adder slice, trading area for W/2-cycle latency.

Parameters:
- W, 8, operand/result width in bits; must be even and >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- x  input  W  operand A; sampled on the accepting edge
- y  input  W  operand B; sampled on the accepting edge
- ci  input  1  carry-in; sampled on the accepting edge
- busy  output  1  high in RUN and DONE; start is ignored while high
- done  output  1  one-cycle pulse; result valid
- s  output  W  sum register
- co  output  1  carry-out register

Behaviour:
- Reset values (rst_n low, asynchronous): state=IDLE, busy=0, done=0, s=0, co=0, pair counter=0, operand shift registers=0, carry register=0.
- States and transitions:
  - IDLE: busy=0. On an edge with start=1: load x, y into shift registers, load ci into the carry register, counter=0, go to RUN.
  - RUN: busy=1. Each edge: the slice adds xs[1:0]+ys[1:0]+carry. The 2-bit sum shifts into the MSB end of the internal accumulator. Slice co goes to the carry register. xs/ys shift right by 2. Counter increments. On the edge where counter==W/2-1: copy the completed accumulator to s and the final carry to co, then go to DONE.
  - DONE: busy=1, done=1 for exactly one cycle, then unconditionally return to IDLE.
- Latency:
  - Accepting start edge = E0. Final RUN edge = E(W/2). done is high between E(W/2) and E(W/2+1).
  - W=8: 4 RUN cycles, done high in the 5th cycle after the start edge. W=2: single RUN cycle.
- Result stability: s and co change only on the final RUN edge. They hold the previous result through IDLE and through a following RUN until that run's final edge.
- Arithmetic: {co,s} = x + y + ci, modulo 2^(W+1). No truncation beyond that.
- start while busy (RUN or DONE): ignored, with no effect on state or latched operands. A start pulse in the DONE cycle is dropped; the requester re-asserts it in IDLE.
- x/y/ci changing after acceptance: no effect on the current operation.
- rst_n low mid-RUN or DONE: abort immediately to the reset values. No done pulse is produced for the aborted operation.
- Counter width: clog2(W/2), minimum 1 bit. The counter never wraps past W/2-1.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), the two's-complement signed overflow of the completed add.
  - ovf = (x[W-1] ~^ y[W-1]) & (s[W-1] ^ x[W-1]), computed from the latched operand MSBs.
  - Registered on the same edge as s/co. Reset to 0; holds like s.
- Undefined: ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- W=8, x=0xA5, y=0x3C, ci=0, start pulse -> busy high from next cycle; done high exactly 5th cycle after start edge; s=0xE1, co=0.
- x=0xFF, y=0x01, ci=0 -> s=0x00, co=1. Then x=0xFF, y=0x00, ci=1 -> s=0x00, co=1. Then x=0x00, y=0x00, ci=0 -> s=0x00, co=0.
- Start x=0x10, y=0x20; during RUN pulse start with x=0xFF, y=0xFF and change inputs -> single done, s=0x30, co=0; no second done; start in DONE cycle dropped.
- Start x=0x55, y=0x55, ci=1; assert rst_n low on the 2nd RUN cycle -> busy, done, s, co go to 0 immediately; no done after release; next start with 0x01+0x02 -> s=0x03.
- SERIAL_ADD_OVF_EN: 0x7F+0x01 -> s=0x80, co=0, ovf=1; 0x80+0x80 -> s=0x00, co=1, ovf=1; 0x7F+0x80 -> s=0xFF, ovf=0.
- W=2 build: x=2'b11, y=2'b01, ci=1 -> done 2nd cycle after start; s=2'b01, co=1.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Purpose: W-bit adder built by time-sharing one 2-bit ripple slice, LSB pair first, carry held in a register.
// Latency: done pulses W/2+1 cycles after the accepting start edge; s/co/ovf update on the final RUN edge.
// Backpressure: start is only honoured in IDLE; busy is high through RUN and DONE and start is dropped then.
//
// Ports: clk, rst_n (async active-low), start/x/y/ci (request + operands, sampled on accept),
//        busy/done (status), s/co (registered result). Optional ovf (signed overflow) is present
//        only when the SERIAL_ADD_OVF_EN macro is defined.

module add2b (
    input  logic [1:0] x_i,
    input  logic [1:0] y_i,
    input  logic       ci_i,
    output logic [1:0] o_o,
    output logic       co_o
);
    logic c1;

    always_comb begin
        o_o[0] = x_i[0] ^ y_i[0] ^ ci_i;
        c1     = (x_i[0] & y_i[0]) | (ci_i & (x_i[0] ^ y_i[0]));
        o_o[1] = x_i[1] ^ y_i[1] ^ c1;
        co_o   = (x_i[1] & y_i[1]) | (c1 & (x_i[1] ^ y_i[1]));
    end
endmodule

module serial_add_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] s,
    output logic         co
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam int NP = W / 2;
    localparam int CW = (NP > 1) ? $clog2(NP) : 1;
    localparam logic [CW-1:0] LAST = CW'(NP - 1);

    generate
        if ((W < 2) || ((W % 2) != 0)) begin : g_bad_width
            $error("serial_add_ctrl: W must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [W-1:0]  xs_q, ys_q, acc_q, s_q;
    logic          carry_q, co_q, busy_q, done_q;
    logic [CW-1:0] cnt_q;

    logic [W-1:0]  xs_d, ys_d, acc_d;
    logic [1:0]    slice_sum;
    logic          slice_co;

    add2b u_slice (
        .x_i  (xs_q[1:0]),
        .y_i  (ys_q[1:0]),
        .ci_i (carry_q),
        .o_o  (slice_sum),
        .co_o (slice_co)
    );

    // New pair enters at the MSB end so that after NP shifts the LSB pair sits at bit 0.
    always_comb begin
        xs_d  = xs_q >> 2;
        ys_d  = ys_q >> 2;
        acc_d = W'({slice_sum, acc_q} >> 2);
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // On the final pair the shift registers hold the original operand MSBs in bit 1,
    // and the slice's upper sum bit becomes the result MSB.
    always_comb begin
        ovf_d = (xs_q[1] ~^ ys_q[1]) & (slice_sum[1] ^ xs_q[1]);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        xs_q    <= x;
                        ys_q    <= y;
                        carry_q <= ci;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    xs_q    <= xs_d;
                    ys_q    <= ys_d;
                    acc_q   <= acc_d;
                    carry_q <= slice_co;
                    if (cnt_q == LAST) begin
                        // Counter holds here rather than wrapping; it is reloaded on the next accept.
                        s_q     <= acc_d;
                        co_q    <= slice_co;
`ifdef SERIAL_ADD_OVF_EN
                        ovf_q   <= ovf_d;
`endif
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign co   = co_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // W=8 instance
    logic       start = 1'b0;
    logic [7:0] x = '0, y = '0;
    logic       ci = 1'b0;
    logic       busy, done, co;
    logic [7:0] s;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf;
`endif

    // W=2 instance
    logic       start2 = 1'b0;
    logic [1:0] x2 = '0, y2 = '0;
    logic       ci2 = 1'b0;
    logic       busy2, done2, co2;
    logic [1:0] s2;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf2;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    serial_add_ctrl #(.W(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .x     (x2),
        .y     (y2),
        .ci    (ci2),
        .busy  (busy2),
        .done  (done2),
        .s     (s2),
        .co    (co2)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("%s mismatch", tag);
        end
    endtask

    // One W=8 operation from IDLE; checks latency, result hold while running, result, and the single-cycle done.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] es, input logic eco, input logic eovf,
                          input logic [7:0] ps, input logic pco);
        int n;
        @(negedge clk);
        start = 1'b1; x = a; y = b; ci = c;
        @(negedge clk);
        start = 1'b0; x = ~a; y = ~b; ci = ~c;
        n = 1;
        chk({tag, ".busy_run"}, 32'(busy), 32'd1);
        chk({tag, ".s_hold"}, 32'(s), 32'(ps));
        chk({tag, ".co_hold"}, 32'(co), 32'(pco));
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'd5);
        chk({tag, ".s"}, 32'(s), 32'(es));
        chk({tag, ".co"}, 32'(co), 32'(eco));
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, ".ovf"}, 32'(ovf), 32'(eovf));
`else
        if (eovf === 1'bx) $display("unexpected x in expected ovf for %s", tag);
`endif
        @(negedge clk);
        chk({tag, ".done_clr"}, 32'(done), 32'd0);
        chk({tag, ".busy_clr"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int dones;

        // Reset state
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.s", 32'(s), 32'd0);
        chk("rst.co", 32'(co), 32'd0);
        chk("rst.s2", 32'(s2), 32'd0);
        chk("rst.busy2", 32'(busy2), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst.ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add and carry cases
        run_op("a5p3c", 8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0, 1'b0, 8'h00, 1'b0);
        run_op("ffp01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8'hE1, 1'b0);
        run_op("ffp00c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
        run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);

        // Start while busy is ignored; start in the DONE cycle is dropped
        @(negedge clk);
        start = 1'b1; x = 8'h10; y = 8'h20; ci = 1'b0;
        @(negedge clk);
        start = 1'b0; n = 1;
        @(negedge clk);
        n++;
        start = 1'b1; x = 8'hFF; y = 8'hFF; ci = 1'b1;
        @(negedge clk);
        n++;
        start = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ign.latency", 32'(n), 32'd5);
        chk("ign.s", 32'(s), 32'h30);
        chk("ign.co", 32'(co), 32'd0);
        start = 1'b1; x = 8'h01; y = 8'h01; ci = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("ign.done_clr", 32'(done), 32'd0);
        chk("ign.busy_drop", 32'(busy), 32'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("ign.no_second_done", 32'(dones), 32'd0);
        chk("ign.s_keep", 32'(s), 32'h30);

        // Reset mid-RUN aborts without a done pulse
        @(negedge clk);
        start = 1'b1; x = 8'h55; y = 8'h55; ci = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort.busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.s", 32'(s), 32'd0);
        chk("abort.co", 32'(co), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        chk("abort.quiet", 32'(dones), 32'd0);
        run_op("post_abort", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0);

        // Signed overflow cases (s/co checked in every build)
        run_op("ovf_pos", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 8'h03, 1'b0);
        run_op("ovf_neg", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 8'h80, 1'b0);
        run_op("ovf_none", 8'h7F, 8'h80, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b1);

        // W=2 instance: single RUN cycle
        @(negedge clk);
        start2 = 1'b1; x2 = 2'b11; y2 = 2'b01; ci2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; x2 = 2'b00; y2 = 2'b00; ci2 = 1'b0;
        n = 1;
        chk("w2.busy", 32'(busy2), 32'd1);
        while (!done2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("w2.latency", 32'(n), 32'd2);
        chk("w2.s", 32'(s2), 32'h1);
        chk("w2.co", 32'(co2), 32'd1);
        @(negedge clk);
        chk("w2.done_clr", 32'(done2), 32'd0);
        chk("w2.busy_clr", 32'(busy2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
